// File: rtl/inst_rom_arbiter.sv
// Two-port arbiter for the shared combinational instruction ROM: IF fetch has
// priority, DBG reads are forced through after MAX_WAIT contested losses.
module inst_rom_arbiter #(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_stall,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              rom_ce,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_inst
);

  localparam int unsigned     CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RESP_IF  = 2'd1,
    ST_RESP_DBG = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_wait_cnt;
  logic [CNT_W-1:0]   w_wait_cnt_nxt;
  logic               w_if_gnt;
  logic               w_dbg_gnt;
  logic [ADDR_W-1:0]  w_rom_addr;
  logic [DATA_W-1:0]  r_if_rdata;
  logic [DATA_W-1:0]  r_dbg_rdata;

  // Grant selection; the starved DBG port wins once its counter saturates.
  always_comb begin
    w_if_gnt  = 1'b0;
    w_dbg_gnt = 1'b0;
    if (if_req && dbg_req) begin
      if (r_wait_cnt == CNT_MAX) begin
        w_dbg_gnt = 1'b1;
      end else begin
        w_if_gnt = 1'b1;
      end
    end else if (if_req) begin
      w_if_gnt = 1'b1;
    end else if (dbg_req) begin
      w_dbg_gnt = 1'b1;
    end else begin
      w_if_gnt  = 1'b0;
      w_dbg_gnt = 1'b0;
    end
  end

  // Starvation counter and response-state next values.
  always_comb begin
    w_wait_cnt_nxt = r_wait_cnt;
    w_state_nxt    = ST_IDLE;
    if (!dbg_req || w_dbg_gnt) begin
      w_wait_cnt_nxt = {CNT_W{1'b0}};
    end else if (r_wait_cnt != CNT_MAX) begin
      w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
    end else begin
      w_wait_cnt_nxt = r_wait_cnt;
    end
    case ({w_if_gnt, w_dbg_gnt})
      2'b10:   w_state_nxt = ST_RESP_IF;
      2'b01:   w_state_nxt = ST_RESP_DBG;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // ROM address mux; zero when nobody is granted.
  always_comb begin
    w_rom_addr = {ADDR_W{1'b0}};
    if (w_if_gnt) begin
      w_rom_addr = if_addr;
    end else if (w_dbg_gnt) begin
      w_rom_addr = dbg_addr;
    end else begin
      w_rom_addr = {ADDR_W{1'b0}};
    end
  end

  // State, counter and per-port read data registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_wait_cnt  <= {CNT_W{1'b0}};
      r_if_rdata  <= {DATA_W{1'b0}};
      r_dbg_rdata <= {DATA_W{1'b0}};
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      if (w_if_gnt) begin
        r_if_rdata <= rom_inst;
      end
      if (w_dbg_gnt) begin
        r_dbg_rdata <= rom_inst;
      end
    end
  end

  // Combinational handshake outputs are forced low while reset is held.
  assign if_gnt     = w_if_gnt & rst;
  assign dbg_gnt    = w_dbg_gnt & rst;
  assign if_stall   = if_req & rst & ~w_if_gnt;
  assign rom_ce     = (w_if_gnt | w_dbg_gnt) & rst;
  assign rom_addr   = rst ? w_rom_addr : {ADDR_W{1'b0}};
  assign if_rvalid  = (r_state == ST_RESP_IF);
  assign dbg_rvalid = (r_state == ST_RESP_DBG);
  assign if_rdata   = r_if_rdata;
  assign dbg_rdata  = r_dbg_rdata;

endmodule

// File: tb/tb_inst_rom_arbiter.sv
// Bench for inst_rom_arbiter: vector table with expected grants, plus a
// scoreboard of ROM words checked when rvalid appears.
module tb_inst_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt;
  logic        if_stall;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        dbg_req;
  logic [31:0] dbg_addr;
  logic        dbg_gnt;
  logic        dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;

  logic [31:0] mem [0:63];

  always #5 clk = ~clk;

  assign rom_inst = mem[rom_addr[7:2]];

  inst_rom_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_stall(if_stall),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .rom_ce(rom_ce), .rom_addr(rom_addr), .rom_inst(rom_inst)
  );

  typedef struct {
    logic        ifr;
    logic [31:0] ifa;
    logic        dr;
    logic [31:0] da;
    logic        eif;
    logic        edbg;
  } vec_t;

  typedef struct {
    logic        port;
    logic [31:0] data;
  } exp_t;

  vec_t        vecs[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  logic [1:0]  m_state = 2'd0;
  logic [31:0] m_if_rdata = 32'd0;
  logic [31:0] m_dbg_rdata = 32'd0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic ifr, input logic [31:0] ifa, input logic dr,
                     input logic [31:0] da, input logic eif, input logic edbg);
    vec_t v;
    v.ifr = ifr; v.ifa = ifa; v.dr = dr; v.da = da; v.eif = eif; v.edbg = edbg;
    vecs.push_back(v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_if_gnt"},     32'(if_gnt),     32'd0);
    chk({tag, "_dbg_gnt"},    32'(dbg_gnt),    32'd0);
    chk({tag, "_if_stall"},   32'(if_stall),   32'd0);
    chk({tag, "_if_rvalid"},  32'(if_rvalid),  32'd0);
    chk({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
    chk({tag, "_rom_ce"},     32'(rom_ce),     32'd0);
    chk({tag, "_rom_addr"},   rom_addr,        32'd0);
    chk({tag, "_if_rdata"},   if_rdata,        32'd0);
    chk({tag, "_dbg_rdata"},  dbg_rdata,       32'd0);
  endtask

  task automatic run_cycle(input vec_t v);
    exp_t        e;
    logic [31:0] exp_addr;
    @(posedge clk);
    #1;
    if_req   = v.ifr;
    if_addr  = v.ifa;
    dbg_req  = v.dr;
    dbg_addr = v.da;
    @(negedge clk);
    exp_addr = v.eif ? v.ifa : (v.edbg ? v.da : 32'd0);
    chk("if_gnt",   32'(if_gnt),   32'(v.eif));
    chk("dbg_gnt",  32'(dbg_gnt),  32'(v.edbg));
    chk("if_stall", 32'(if_stall), 32'(v.ifr & ~v.eif));
    chk("rom_ce",   32'(rom_ce),   32'(v.eif | v.edbg));
    chk("rom_addr", rom_addr,      exp_addr);
    chk("if_rvalid",  32'(if_rvalid),  32'(m_state == 2'd1));
    chk("dbg_rvalid", 32'(dbg_rvalid), 32'(m_state == 2'd2));
    if (m_state != 2'd0) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL sb_empty: got rvalid expected a queued word at %0t", $time);
      end else begin
        e = sb.pop_front();
        if (e.port == 1'b0) m_if_rdata = e.data;
        else m_dbg_rdata = e.data;
      end
    end
    chk("if_rdata",  if_rdata,  m_if_rdata);
    chk("dbg_rdata", dbg_rdata, m_dbg_rdata);
    if (v.eif) begin
      e.port = 1'b0; e.data = mem[v.ifa[7:2]];
      sb.push_back(e);
      m_state = 2'd1;
    end else if (v.edbg) begin
      e.port = 1'b1; e.data = mem[v.da[7:2]];
      sb.push_back(e);
      m_state = 2'd2;
    end else begin
      m_state = 2'd0;
    end
  endtask

  initial begin
    vec_t idle;
    idle.ifr = 1'b0; idle.ifa = 32'd0; idle.dr = 1'b0; idle.da = 32'd0;
    idle.eif = 1'b0; idle.edbg = 1'b0;

    for (int i = 0; i < 64; i++) begin
      mem[i] = 32'hA500_0000 | (32'(i) << 8) | ($urandom & 32'hFF);
    end

    // IF alone on consecutive words
    add(1'b1, 32'h00, 1'b0, 32'h00, 1'b1, 1'b0);
    add(1'b1, 32'h04, 1'b0, 32'h00, 1'b1, 1'b0);
    add(1'b1, 32'h08, 1'b0, 32'h00, 1'b1, 1'b0);
    add(1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0);
    // DBG alone
    add(1'b0, 32'h00, 1'b1, 32'h10, 1'b0, 1'b1);
    add(1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0);
    // Both held: DBG forced through on the fifth contested cycle
    add(1'b1, 32'h20, 1'b1, 32'h40, 1'b1, 1'b0);
    add(1'b1, 32'h24, 1'b1, 32'h40, 1'b1, 1'b0);
    add(1'b1, 32'h28, 1'b1, 32'h40, 1'b1, 1'b0);
    add(1'b1, 32'h2C, 1'b1, 32'h40, 1'b1, 1'b0);
    add(1'b1, 32'h30, 1'b1, 32'h40, 1'b0, 1'b1);
    add(1'b1, 32'h30, 1'b0, 32'h00, 1'b1, 1'b0);
    add(1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0);
    // DBG withdrawn after two losses: counter restarts
    add(1'b1, 32'h50, 1'b1, 32'h60, 1'b1, 1'b0);
    add(1'b1, 32'h54, 1'b1, 32'h60, 1'b1, 1'b0);
    add(1'b1, 32'h58, 1'b0, 32'h00, 1'b1, 1'b0);
    add(1'b1, 32'h5C, 1'b1, 32'h60, 1'b1, 1'b0);
    add(1'b1, 32'h64, 1'b1, 32'h60, 1'b1, 1'b0);
    add(1'b1, 32'h68, 1'b1, 32'h60, 1'b1, 1'b0);
    add(1'b1, 32'h6C, 1'b1, 32'h60, 1'b1, 1'b0);
    add(1'b1, 32'h70, 1'b1, 32'h60, 1'b0, 1'b1);
    add(1'b1, 32'h70, 1'b0, 32'h00, 1'b1, 1'b0);
    // back-to-back DBG reads
    add(1'b0, 32'h00, 1'b1, 32'h80, 1'b0, 1'b1);
    add(1'b0, 32'h00, 1'b1, 32'h84, 1'b0, 1'b1);
    add(1'b0, 32'h00, 1'b0, 32'h00, 1'b0, 1'b0);

    // reset held with random requests
    rst = 1'b0;
    if_req = 1'b0; if_addr = 32'd0; dbg_req = 1'b0; dbg_addr = 32'd0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if_req   = 1'($urandom);
      if_addr  = $urandom & 32'hFC;
      dbg_req  = 1'($urandom);
      dbg_addr = $urandom & 32'hFC;
      @(negedge clk);
      check_all_zero("rst_hold");
    end
    if_req  = 1'b0;
    dbg_req = 1'b0;
    rst     = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      run_cycle(vecs[i]);
    end

    // reset in the cycle after an IF grant drops the pending response
    idle.ifr = 1'b1; idle.ifa = 32'h0C; idle.eif = 1'b1;
    run_cycle(idle);
    @(posedge clk);
    #1;
    rst     = 1'b0;
    if_req  = 1'b0;
    dbg_req = 1'b0;
    #1;
    check_all_zero("rst_mid");
    sb.delete();
    m_state     = 2'd0;
    m_if_rdata  = 32'd0;
    m_dbg_rdata = 32'd0;
    @(negedge clk);
    rst = 1'b1;
    idle.ifr = 1'b0; idle.ifa = 32'd0; idle.eif = 1'b0;
    run_cycle(idle);
    run_cycle(idle);
    idle.dr = 1'b1; idle.da = 32'h14; idle.edbg = 1'b1;
    run_cycle(idle);
    idle.dr = 1'b0; idle.da = 32'd0; idle.edbg = 1'b0;
    run_cycle(idle);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
